// File: rtl/ysyx_23060136_wbu_pkg.sv
// Shared types for the ysyx_23060136 write-back stage.
//   wbu_state_e : stage FSM states
//   load_size_t : one-hot load size flags from the memory stage
//   wb_entry_t  : one retiring instruction as held by the stage
package ysyx_23060136_wbu_pkg;

    localparam int unsigned BITS_W = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned GPR_W  = 5;
    localparam int unsigned CSR_W  = 4;

    localparam logic [BITS_W-1:0] MCAUSE_ECALL_M = BITS_W'(11);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HALT  = 2'd2
    } wbu_state_e;

    typedef struct packed {
        logic byte_s;
        logic half_s;
        logic word_s;
        logic dword;
        logic byte_u;
        logic half_u;
        logic word_u;
    } load_size_t;

    typedef struct packed {
        logic [BITS_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              commit;
        logic [GPR_W-1:0]  rd;
        logic              write_gpr;
        logic              mem_to_reg;
        logic [BITS_W-1:0] alu_result;
        logic [BITS_W-1:0] mem_rdata;
        logic [BITS_W-1:0] csr_rs_data;
        logic [BITS_W-1:0] csr_wdata;
        load_size_t        size;
        logic              write_csr_1;
        logic              write_csr_2;
        logic [CSR_W-1:0]  csr_rd_1;
        logic [CSR_W-1:0]  csr_rd_2;
        logic              csrrs;
        logic              csrrw;
        logic              ecall;
        logic              system_halt;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_23060136_WBU_LOAD_EXT.sv
// Combinational load extension of right-aligned memory read data.
//   size  : one-hot load size
//   rdata : raw read data, value in the low bits
//   data  : sign/zero-extended result
//   hit   : a size flag was set (data is meaningful)
module ysyx_23060136_WBU_LOAD_EXT
    import ysyx_23060136_wbu_pkg::*;
(
    input  load_size_t        size,
    input  logic [BITS_W-1:0] rdata,
    output logic [BITS_W-1:0] data,
    output logic              hit
);

    always_comb begin
        data = '0;
        hit  = 1'b1;
        if (size.byte_s) begin
            data = {{(BITS_W-8){rdata[7]}}, rdata[7:0]};
        end else if (size.half_s) begin
            data = {{(BITS_W-16){rdata[15]}}, rdata[15:0]};
        end else if (size.word_s) begin
            data = {{(BITS_W-32){rdata[31]}}, rdata[31:0]};
        end else if (size.dword) begin
            data = rdata;
        end else if (size.byte_u) begin
            data = BITS_W'(rdata[7:0]);
        end else if (size.half_u) begin
            data = BITS_W'(rdata[15:0]);
        end else if (size.word_u) begin
            data = BITS_W'(rdata[31:0]);
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_23060136_wbu_top.sv
// Write-back stage: holds one retiring instruction, drives the GPR and
// dual CSR write ports, the commit pulse, retire counter and sticky halt.
//   MEM_o_*  : entry from the memory stage (valid/ready handshake)
//   WB_o_*   : register-file write ports and retire status
//   rst      : asynchronous, active-low
module ysyx_23060136_wbu_top
    import ysyx_23060136_wbu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_o_valid,
    output logic              WBU_o_ready,
    input  logic [BITS_W-1:0] MEM_o_pc,
    input  logic [INST_W-1:0] MEM_o_inst,
    input  logic              MEM_o_commit,
    input  logic [GPR_W-1:0]  MEM_o_rd,
    input  logic              MEM_o_write_gpr,
    input  logic              MEM_o_mem_to_reg,
    input  logic [BITS_W-1:0] MEM_o_alu_result,
    input  logic [BITS_W-1:0] MEM_o_mem_rdata,
    input  logic [BITS_W-1:0] MEM_o_csr_rs_data,
    input  logic [BITS_W-1:0] MEM_o_csr_wdata,
    input  logic              MEM_o_mem_byte,
    input  logic              MEM_o_mem_half,
    input  logic              MEM_o_mem_word,
    input  logic              MEM_o_mem_dword,
    input  logic              MEM_o_mem_byte_u,
    input  logic              MEM_o_mem_half_u,
    input  logic              MEM_o_mem_word_u,
    input  logic              MEM_o_write_csr_1,
    input  logic              MEM_o_write_csr_2,
    input  logic [CSR_W-1:0]  MEM_o_csr_rd_1,
    input  logic [CSR_W-1:0]  MEM_o_csr_rd_2,
    input  logic              MEM_o_rv64_csrrs,
    input  logic              MEM_o_rv64_csrrw,
    input  logic              MEM_o_rv64_ecall,
    input  logic              MEM_o_system_halt,
    output logic [GPR_W-1:0]  WB_o_rd,
    output logic              WB_o_RegWr,
    output logic [BITS_W-1:0] WB_o_rf_busW,
    output logic [CSR_W-1:0]  WB_o_csr_rd_1,
    output logic [CSR_W-1:0]  WB_o_csr_rd_2,
    output logic              WB_o_CSRWr_1,
    output logic              WB_o_CSRWr_2,
    output logic [BITS_W-1:0] WB_o_csr_busW_1,
    output logic [BITS_W-1:0] WB_o_csr_busW_2,
    output logic              WB_o_commit,
    output logic [BITS_W-1:0] WB_o_pc,
    output logic [INST_W-1:0] WB_o_inst,
    output logic [63:0]       WB_o_retire_cnt,
    output logic              WB_o_halt
);

    wbu_state_e        state_q, state_d;
    wb_entry_t         entry_q, entry_in;
    logic              accept;
    logic [63:0]       retire_cnt_q;
    logic [BITS_W-1:0] load_data;
    logic              load_hit;

    assign entry_in = '{
        pc:          MEM_o_pc,
        inst:        MEM_o_inst,
        commit:      MEM_o_commit,
        rd:          MEM_o_rd,
        write_gpr:   MEM_o_write_gpr,
        mem_to_reg:  MEM_o_mem_to_reg,
        alu_result:  MEM_o_alu_result,
        mem_rdata:   MEM_o_mem_rdata,
        csr_rs_data: MEM_o_csr_rs_data,
        csr_wdata:   MEM_o_csr_wdata,
        size:        '{byte_s: MEM_o_mem_byte,   half_s: MEM_o_mem_half,
                       word_s: MEM_o_mem_word,   dword:  MEM_o_mem_dword,
                       byte_u: MEM_o_mem_byte_u, half_u: MEM_o_mem_half_u,
                       word_u: MEM_o_mem_word_u},
        write_csr_1: MEM_o_write_csr_1,
        write_csr_2: MEM_o_write_csr_2,
        csr_rd_1:    MEM_o_csr_rd_1,
        csr_rd_2:    MEM_o_csr_rd_2,
        csrrs:       MEM_o_rv64_csrrs,
        csrrw:       MEM_o_rv64_csrrw,
        ecall:       MEM_o_rv64_ecall,
        system_halt: MEM_o_system_halt
    };

    assign WBU_o_ready = (state_q != ST_HALT);
    assign accept      = MEM_o_valid & WBU_o_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and write strobes
    always_comb begin
        state_d      = state_q;
        WB_o_RegWr   = 1'b0;
        WB_o_CSRWr_1 = 1'b0;
        WB_o_CSRWr_2 = 1'b0;
        WB_o_commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                WB_o_RegWr   = entry_q.write_gpr & (entry_q.rd != '0);
                WB_o_CSRWr_1 = entry_q.write_csr_1;
                WB_o_CSRWr_2 = entry_q.write_csr_2;
                WB_o_commit  = entry_q.commit;
                if (entry_q.system_halt) state_d = ST_HALT;
                else if (accept)         state_d = ST_WRITE;
                else                     state_d = ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Entry register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else if (accept) begin
            entry_q <= entry_in;
        end
    end

    // Count each entry as it enters WRITE, so the value seen alongside its
    // commit pulse already includes it; an entry dropped by halting never counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_q <= '0;
        end else if (state_d == ST_WRITE && MEM_o_commit) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    ysyx_23060136_WBU_LOAD_EXT u_load_ext (
        .size  (entry_q.size),
        .rdata (entry_q.mem_rdata),
        .data  (load_data),
        .hit   (load_hit)
    );

    // GPR and CSR write data from the held entry
    always_comb begin
        WB_o_rf_busW    = entry_q.alu_result;
        WB_o_csr_busW_1 = '0;
        WB_o_csr_busW_2 = '0;
        if (entry_q.mem_to_reg) begin
            if (load_hit) WB_o_rf_busW = load_data;
        end else if (entry_q.csrrs | entry_q.csrrw) begin
            WB_o_rf_busW = entry_q.csr_rs_data;
        end
        if (entry_q.ecall) begin
            WB_o_csr_busW_1 = entry_q.pc;
            WB_o_csr_busW_2 = MCAUSE_ECALL_M;
        end else if (entry_q.csrrs | entry_q.csrrw) begin
            WB_o_csr_busW_1 = entry_q.csr_wdata;
        end
    end

    assign WB_o_rd         = entry_q.rd;
    assign WB_o_csr_rd_1   = entry_q.csr_rd_1;
    assign WB_o_csr_rd_2   = entry_q.csr_rd_2;
    assign WB_o_pc         = entry_q.pc;
    assign WB_o_inst       = entry_q.inst;
    assign WB_o_retire_cnt = retire_cnt_q;
    assign WB_o_halt       = (state_q == ST_HALT);

endmodule

// File: tb/tb_ysyx_23060136_wbu_top.sv
// Self-checking bench for the ysyx_23060136 write-back stage.
module tb_ysyx_23060136_wbu_top;
    import ysyx_23060136_wbu_pkg::*;

    localparam logic [6:0] SZ_NONE = 7'b0000000;
    localparam logic [6:0] SZ_B    = 7'b1000000;
    localparam logic [6:0] SZ_H    = 7'b0100000;
    localparam logic [6:0] SZ_W    = 7'b0010000;
    localparam logic [6:0] SZ_D    = 7'b0001000;
    localparam logic [6:0] SZ_BU   = 7'b0000100;
    localparam logic [6:0] SZ_HU   = 7'b0000010;
    localparam logic [6:0] SZ_WU   = 7'b0000001;

    logic        clk, rst;
    logic        MEM_o_valid, WBU_o_ready;
    logic [63:0] MEM_o_pc;
    logic [31:0] MEM_o_inst;
    logic        MEM_o_commit;
    logic [4:0]  MEM_o_rd;
    logic        MEM_o_write_gpr, MEM_o_mem_to_reg;
    logic [63:0] MEM_o_alu_result, MEM_o_mem_rdata, MEM_o_csr_rs_data, MEM_o_csr_wdata;
    logic        MEM_o_mem_byte, MEM_o_mem_half, MEM_o_mem_word, MEM_o_mem_dword;
    logic        MEM_o_mem_byte_u, MEM_o_mem_half_u, MEM_o_mem_word_u;
    logic        MEM_o_write_csr_1, MEM_o_write_csr_2;
    logic [3:0]  MEM_o_csr_rd_1, MEM_o_csr_rd_2;
    logic        MEM_o_rv64_csrrs, MEM_o_rv64_csrrw, MEM_o_rv64_ecall, MEM_o_system_halt;
    logic [4:0]  WB_o_rd;
    logic        WB_o_RegWr;
    logic [63:0] WB_o_rf_busW;
    logic [3:0]  WB_o_csr_rd_1, WB_o_csr_rd_2;
    logic        WB_o_CSRWr_1, WB_o_CSRWr_2;
    logic [63:0] WB_o_csr_busW_1, WB_o_csr_busW_2;
    logic        WB_o_commit;
    logic [63:0] WB_o_pc;
    logic [31:0] WB_o_inst;
    logic [63:0] WB_o_retire_cnt;
    logic        WB_o_halt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_cnt = 0;

    ysyx_23060136_wbu_top dut (
        .clk(clk), .rst(rst),
        .MEM_o_valid(MEM_o_valid), .WBU_o_ready(WBU_o_ready),
        .MEM_o_pc(MEM_o_pc), .MEM_o_inst(MEM_o_inst), .MEM_o_commit(MEM_o_commit),
        .MEM_o_rd(MEM_o_rd), .MEM_o_write_gpr(MEM_o_write_gpr),
        .MEM_o_mem_to_reg(MEM_o_mem_to_reg), .MEM_o_alu_result(MEM_o_alu_result),
        .MEM_o_mem_rdata(MEM_o_mem_rdata), .MEM_o_csr_rs_data(MEM_o_csr_rs_data),
        .MEM_o_csr_wdata(MEM_o_csr_wdata),
        .MEM_o_mem_byte(MEM_o_mem_byte), .MEM_o_mem_half(MEM_o_mem_half),
        .MEM_o_mem_word(MEM_o_mem_word), .MEM_o_mem_dword(MEM_o_mem_dword),
        .MEM_o_mem_byte_u(MEM_o_mem_byte_u), .MEM_o_mem_half_u(MEM_o_mem_half_u),
        .MEM_o_mem_word_u(MEM_o_mem_word_u),
        .MEM_o_write_csr_1(MEM_o_write_csr_1), .MEM_o_write_csr_2(MEM_o_write_csr_2),
        .MEM_o_csr_rd_1(MEM_o_csr_rd_1), .MEM_o_csr_rd_2(MEM_o_csr_rd_2),
        .MEM_o_rv64_csrrs(MEM_o_rv64_csrrs), .MEM_o_rv64_csrrw(MEM_o_rv64_csrrw),
        .MEM_o_rv64_ecall(MEM_o_rv64_ecall), .MEM_o_system_halt(MEM_o_system_halt),
        .WB_o_rd(WB_o_rd), .WB_o_RegWr(WB_o_RegWr), .WB_o_rf_busW(WB_o_rf_busW),
        .WB_o_csr_rd_1(WB_o_csr_rd_1), .WB_o_csr_rd_2(WB_o_csr_rd_2),
        .WB_o_CSRWr_1(WB_o_CSRWr_1), .WB_o_CSRWr_2(WB_o_CSRWr_2),
        .WB_o_csr_busW_1(WB_o_csr_busW_1), .WB_o_csr_busW_2(WB_o_csr_busW_2),
        .WB_o_commit(WB_o_commit), .WB_o_pc(WB_o_pc), .WB_o_inst(WB_o_inst),
        .WB_o_retire_cnt(WB_o_retire_cnt), .WB_o_halt(WB_o_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        wb_entry_t   e;
        logic [63:0] exp_busw;
        logic        exp_regwr;
    } vec_t;

    vec_t vecs[12];

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_load(input logic [6:0] sz, input logic [63:0] d,
                                              input logic [63:0] alu);
        logic [63:0] r;
        case (sz)
            SZ_B:    r = {{56{d[7]}},  d[7:0]};
            SZ_H:    r = {{48{d[15]}}, d[15:0]};
            SZ_W:    r = {{32{d[31]}}, d[31:0]};
            SZ_D:    r = d;
            SZ_BU:   r = d & 64'hFF;
            SZ_HU:   r = d & 64'hFFFF;
            SZ_WU:   r = d & 64'hFFFF_FFFF;
            default: r = alu;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ref_busw(input wb_entry_t e);
        if (e.mem_to_reg) return ref_load(7'(e.size), e.mem_rdata, e.alu_result);
        if (e.csrrs || e.csrrw) return e.csr_rs_data;
        return e.alu_result;
    endfunction

    function automatic logic [63:0] ref_csr1(input wb_entry_t e);
        if (e.ecall) return e.pc;
        if (e.csrrs || e.csrrw) return e.csr_wdata;
        return 64'd0;
    endfunction

    function automatic logic [63:0] ref_csr2(input wb_entry_t e);
        return e.ecall ? 64'd11 : 64'd0;
    endfunction

    function automatic wb_entry_t mk_e(input logic [4:0] rd, input logic wg, input logic m2r,
                                       input logic [63:0] alu, input logic [63:0] rdata,
                                       input logic [6:0] sz, input logic csrrw,
                                       input logic [63:0] rs);
        wb_entry_t e;
        e             = '0;
        e.pc          = 64'h8000_0100;
        e.inst        = 32'h0000_0013;
        e.commit      = 1'b1;
        e.rd          = rd;
        e.write_gpr   = wg;
        e.mem_to_reg  = m2r;
        e.alu_result  = alu;
        e.mem_rdata   = rdata;
        e.size        = load_size_t'(sz);
        e.csrrw       = csrrw;
        e.csr_rs_data = rs;
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input wb_entry_t e, input logic v);
        MEM_o_valid       = v;
        MEM_o_pc          = e.pc;
        MEM_o_inst        = e.inst;
        MEM_o_commit      = e.commit;
        MEM_o_rd          = e.rd;
        MEM_o_write_gpr   = e.write_gpr;
        MEM_o_mem_to_reg  = e.mem_to_reg;
        MEM_o_alu_result  = e.alu_result;
        MEM_o_mem_rdata   = e.mem_rdata;
        MEM_o_csr_rs_data = e.csr_rs_data;
        MEM_o_csr_wdata   = e.csr_wdata;
        MEM_o_mem_byte    = e.size.byte_s;
        MEM_o_mem_half    = e.size.half_s;
        MEM_o_mem_word    = e.size.word_s;
        MEM_o_mem_dword   = e.size.dword;
        MEM_o_mem_byte_u  = e.size.byte_u;
        MEM_o_mem_half_u  = e.size.half_u;
        MEM_o_mem_word_u  = e.size.word_u;
        MEM_o_write_csr_1 = e.write_csr_1;
        MEM_o_write_csr_2 = e.write_csr_2;
        MEM_o_csr_rd_1    = e.csr_rd_1;
        MEM_o_csr_rd_2    = e.csr_rd_2;
        MEM_o_rv64_csrrs  = e.csrrs;
        MEM_o_rv64_csrrw  = e.csrrw;
        MEM_o_rv64_ecall  = e.ecall;
        MEM_o_system_halt = e.system_halt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the write ports against the model for an entry in WRITE, or
    // check that every strobe is quiet when nothing is retiring.
    task automatic chk_entry(input string tag, input wb_entry_t e, input logic active);
        if (active) begin
            chk({tag, " RegWr"},  64'(WB_o_RegWr),  64'(e.write_gpr && e.rd != 5'd0));
            chk({tag, " rd"},     64'(WB_o_rd),     64'(e.rd));
            chk({tag, " busW"},   WB_o_rf_busW,     ref_busw(e));
            chk({tag, " CSRWr1"}, 64'(WB_o_CSRWr_1), 64'(e.write_csr_1));
            chk({tag, " CSRWr2"}, 64'(WB_o_CSRWr_2), 64'(e.write_csr_2));
            chk({tag, " csrrd1"}, 64'(WB_o_csr_rd_1), 64'(e.csr_rd_1));
            chk({tag, " csrrd2"}, 64'(WB_o_csr_rd_2), 64'(e.csr_rd_2));
            chk({tag, " csrW1"},  WB_o_csr_busW_1,  ref_csr1(e));
            chk({tag, " csrW2"},  WB_o_csr_busW_2,  ref_csr2(e));
            chk({tag, " commit"}, 64'(WB_o_commit), 64'(e.commit));
            chk({tag, " pc"},     WB_o_pc,          e.pc);
            chk({tag, " inst"},   64'(WB_o_inst),   64'(e.inst));
        end else begin
            chk({tag, " idle RegWr"},  64'(WB_o_RegWr),   64'd0);
            chk({tag, " idle CSRWr1"}, 64'(WB_o_CSRWr_1), 64'd0);
            chk({tag, " idle CSRWr2"}, 64'(WB_o_CSRWr_2), 64'd0);
            chk({tag, " idle commit"}, 64'(WB_o_commit),  64'd0);
        end
        chk({tag, " retire_cnt"}, WB_o_retire_cnt, exp_cnt);
    endtask

    function automatic wb_entry_t rand_entry();
        wb_entry_t e;
        int k, op;
        e             = '0;
        e.pc          = {$urandom, $urandom};
        e.inst        = $urandom;
        e.commit      = ($urandom_range(0, 9) != 0);
        e.rd          = 5'($urandom);
        e.write_gpr   = 1'($urandom);
        e.mem_to_reg  = 1'($urandom);
        e.alu_result  = {$urandom, $urandom};
        e.mem_rdata   = {$urandom, $urandom};
        e.csr_rs_data = {$urandom, $urandom};
        e.csr_wdata   = {$urandom, $urandom};
        k = $urandom_range(0, 7);
        e.size        = (k == 7) ? load_size_t'(SZ_NONE) : load_size_t'(7'(1 << k));
        e.write_csr_1 = 1'($urandom);
        e.write_csr_2 = 1'($urandom);
        e.csr_rd_1    = 4'($urandom);
        e.csr_rd_2    = 4'($urandom);
        op = $urandom_range(0, 3);
        e.csrrw       = (op == 1);
        e.csrrs       = (op == 2);
        e.ecall       = (op == 3);
        return e;
    endfunction

    // ---------------- test ----------------
    initial begin
        wb_entry_t e, idle_e;
        idle_e = '0;

        vecs[0]  = '{"addi",    mk_e(5'd5, 1, 0, 64'h1234, 0, SZ_NONE, 0, 0), 64'h1234, 1'b1};
        vecs[1]  = '{"lb",      mk_e(5'd6, 1, 1, 0, 64'h80, SZ_B, 0, 0), 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
        vecs[2]  = '{"lbu",     mk_e(5'd6, 1, 1, 0, 64'h80, SZ_BU, 0, 0), 64'h80, 1'b1};
        vecs[3]  = '{"lb_hi",   mk_e(5'd7, 1, 1, 0, 64'h1234_5678_9ABC_DE80, SZ_B, 0, 0), 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
        vecs[4]  = '{"lh",      mk_e(5'd8, 1, 1, 0, 64'h8001, SZ_H, 0, 0), 64'hFFFF_FFFF_FFFF_8001, 1'b1};
        vecs[5]  = '{"lhu",     mk_e(5'd8, 1, 1, 0, 64'hAAAA_8001, SZ_HU, 0, 0), 64'h8001, 1'b1};
        vecs[6]  = '{"lw",      mk_e(5'd9, 1, 1, 0, 64'h8000_0000, SZ_W, 0, 0), 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[7]  = '{"lwu",     mk_e(5'd9, 1, 1, 0, 64'h5555_FFFF_FFFF, SZ_WU, 0, 0), 64'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{"ld",      mk_e(5'd10, 1, 1, 0, 64'hDEAD_BEEF_0123_4567, SZ_D, 0, 0), 64'hDEAD_BEEF_0123_4567, 1'b1};
        vecs[9]  = '{"nosize",  mk_e(5'd11, 1, 1, 64'h55, 64'hFFFF, SZ_NONE, 0, 0), 64'h55, 1'b1};
        vecs[10] = '{"csrrw",   mk_e(5'd3, 1, 0, 64'h1, 0, SZ_NONE, 1, 64'hABC), 64'hABC, 1'b1};
        vecs[11] = '{"rd0",     mk_e(5'd0, 1, 0, 64'h7, 0, SZ_NONE, 0, 0), 64'h7, 1'b0};

        // reset state
        rst = 1'b1;
        drive(idle_e, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("rst RegWr",  64'(WB_o_RegWr),  64'd0);
        chk("rst commit", 64'(WB_o_commit), 64'd0);
        chk("rst cnt",    WB_o_retire_cnt,  64'd0);
        chk("rst halt",   64'(WB_o_halt),   64'd0);
        chk("rst busW",   WB_o_rf_busW,     64'd0);
        chk("rst pc",     WB_o_pc,          64'd0);
        #10 rst = 1'b1;
        step();
        chk("ready after reset", 64'(WBU_o_ready), 64'd1);

        // table vectors, each a single isolated entry
        foreach (vecs[i]) begin
            drive(vecs[i].e, 1'b1);
            step();
            exp_cnt++;
            chk_entry(vecs[i].name, vecs[i].e, 1'b1);
            chk({vecs[i].name, " busW const"}, WB_o_rf_busW, vecs[i].exp_busw);
            chk({vecs[i].name, " RegWr const"}, 64'(WB_o_RegWr), 64'(vecs[i].exp_regwr));
            drive(idle_e, 1'b0);
            step();
            chk_entry({vecs[i].name, " after"}, idle_e, 1'b0);
        end

        // ecall
        e = mk_e(5'd0, 0, 0, 0, 0, SZ_NONE, 0, 0);
        e.pc = 64'h8000_0010; e.ecall = 1'b1;
        e.write_csr_1 = 1'b1; e.write_csr_2 = 1'b1;
        e.csr_rd_1 = 4'd2; e.csr_rd_2 = 4'd3;
        drive(e, 1'b1);
        step();
        exp_cnt++;
        chk_entry("ecall", e, 1'b1);
        chk("ecall mepc",   WB_o_csr_busW_1, 64'h8000_0010);
        chk("ecall mcause", WB_o_csr_busW_2, 64'd11);
        drive(idle_e, 1'b0);
        step();
        chk_entry("ecall after", idle_e, 1'b0);

        // 8 back-to-back entries
        for (int k = 0; k < 8; k++) begin
            e = mk_e(5'(k + 1), 1, 0, 64'(100 + k), 0, SZ_NONE, 0, 0);
            e.pc = 64'h8000_0200 + 64'(4 * k);
            drive(e, 1'b1);
            chk($sformatf("b2b%0d ready", k), 64'(WBU_o_ready), 64'd1);
            step();
            exp_cnt++;
            chk_entry($sformatf("b2b%0d", k), e, 1'b1);
        end
        drive(idle_e, 1'b0);
        step();
        chk_entry("b2b end", idle_e, 1'b0);

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic v;
            e = rand_entry();
            v = ($urandom_range(0, 3) != 0);
            drive(e, v);
            chk("rnd ready", 64'(WBU_o_ready), 64'd1);
            step();
            if (v && e.commit) exp_cnt++;
            chk_entry($sformatf("rnd%0d", n), e, v);
        end
        drive(idle_e, 1'b0);
        step();
        chk_entry("rnd end", idle_e, 1'b0);

        // halting entry followed by more valid traffic
        e = mk_e(5'd1, 1, 0, 64'h42, 0, SZ_NONE, 0, 0);
        e.system_halt = 1'b1;
        drive(e, 1'b1);
        step();
        exp_cnt++;
        chk_entry("halt entry", e, 1'b1);
        chk("halt low during write", 64'(WB_o_halt), 64'd0);
        drive(mk_e(5'd7, 1, 0, 64'h99, 0, SZ_NONE, 0, 0), 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_entry($sformatf("halted%0d", k), idle_e, 1'b0);
            chk("halt sticky", 64'(WB_o_halt), 64'd1);
            chk("halt ready",  64'(WBU_o_ready), 64'd0);
        end

        // reset out of HALT
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rst halt clr", 64'(WB_o_halt), 64'd0);
        chk("rst cnt clr",  WB_o_retire_cnt, 64'd0);
        #3 rst = 1'b1;
        drive(idle_e, 1'b0);
        step();
        chk("ready after halt reset", 64'(WBU_o_ready), 64'd1);
        chk_entry("post reset", idle_e, 1'b0);

        // async reset in the middle of a WRITE cycle
        e = mk_e(5'd12, 1, 0, 64'h77, 0, SZ_NONE, 0, 0);
        e.write_csr_1 = 1'b1;
        drive(e, 1'b1);
        step();
        exp_cnt++;
        chk_entry("pre reset write", e, 1'b1);
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        chk("midrst RegWr",  64'(WB_o_RegWr),   64'd0);
        chk("midrst CSRWr1", 64'(WB_o_CSRWr_1), 64'd0);
        chk("midrst commit", 64'(WB_o_commit),  64'd0);
        chk("midrst cnt",    WB_o_retire_cnt,   64'd0);
        chk("midrst pc",     WB_o_pc,           64'd0);
        #2 rst = 1'b1;
        drive(idle_e, 1'b0);
        step();
        chk_entry("after midrst", idle_e, 1'b0);
        chk("after midrst ready", 64'(WBU_o_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060136_wbu_top.md
# ysyx_23060136_wbu_top

Write-back stage of the ysyx_23060136 pipeline and the writer end of the decode stage's register-file interface. Captures one retiring instruction per cycle from the memory stage over a valid/ready handshake, forms the GPR and dual-CSR write data (load extension, CSR read-old-value, ecall mepc/mcause), and drives the `WB_o_*` write ports consumed by the GPR and CSR files in decode. Also produces the commit pulse, a retired-instruction counter and the sticky halt indication.

## Interface
- BITS_W, 64, datapath width
- INST_W, 32, instruction width
- GPR_W, 5, GPR index width
- CSR_W, 4, internal CSR index width (as produced by CSR decode)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- MEM_o_valid  in  1  upstream entry valid
- WBU_o_ready  out  1  stage can accept
- MEM_o_pc, MEM_o_inst, MEM_o_commit  in  BITS_W/INST_W/1  pass-through fields
- MEM_o_rd  in  GPR_W  destination GPR
- MEM_o_write_gpr, MEM_o_mem_to_reg  in  1 each  GPR write enable / select load data
- MEM_o_alu_result, MEM_o_mem_rdata, MEM_o_csr_rs_data, MEM_o_csr_wdata  in  BITS_W each
- MEM_o_mem_byte/half/word/dword/byte_u/half_u/word_u  in  1 each  load size (one-hot)
- MEM_o_write_csr_1, MEM_o_write_csr_2, MEM_o_csr_rd_1, MEM_o_csr_rd_2  in  1,1,CSR_W,CSR_W
- MEM_o_rv64_csrrs, MEM_o_rv64_csrrw, MEM_o_rv64_ecall, MEM_o_system_halt  in  1 each
- WB_o_rd, WB_o_RegWr, WB_o_rf_busW  out  GPR_W,1,BITS_W  GPR write port
- WB_o_csr_rd_1/2, WB_o_CSRWr_1/2, WB_o_csr_busW_1/2  out  CSR_W,1,BITS_W  CSR write ports
- WB_o_commit  out  1  one-cycle retire pulse; WB_o_pc, WB_o_inst  out  retiring pc/inst
- WB_o_retire_cnt  out  64  retired-instruction count
- WB_o_halt  out  1  sticky halt

## Operation
- States: IDLE (no entry), WRITE (entry held, ports driven), HALT.
- Accept = MEM_o_valid & WBU_o_ready; WBU_o_ready = (state != HALT).
- IDLE: accept -> WRITE. WRITE: entry retires this cycle; if entry.system_halt -> HALT; else accept -> WRITE, else -> IDLE. HALT: terminal until reset; inputs ignored.
- Write strobes (RegWr, CSRWr_1/2, commit) asserted only in WRITE; all zero in IDLE/HALT.
- WB_o_RegWr = write_gpr & (rd != 0).
- rf_busW priority: mem_to_reg -> extended mem_rdata; else csrrs|csrrw -> csr_rs_data; else alu_result.
- Load extension of right-aligned mem_rdata: byte/half/word sign-extend bits 7/15/31; *_u zero-extend; dword unchanged. No size flag with mem_to_reg -> alu_result (defensive).
- CSR: ecall -> busW_1 = pc (mepc), busW_2 = 64'd11 (mcause); csrrw/csrrs -> busW_1 = csr_wdata, busW_2 = 0. CSRWr_n = write_csr_n.
- retire_cnt += 1 on every WRITE cycle with commit=1; wraps modulo 2^64.

## Timing
- Entry captured at edge N; ports driven combinationally from the held entry during cycle N+1; files write at edge N+1. Latency 1 cycle; throughput 1/cycle (retire and accept on the same edge).
- WB_o_halt rises on the edge ending the halting entry's WRITE cycle; that entry's own writes and commit still occur.
- Reset (async, any time): state IDLE, entry cleared, all outputs 0, retire_cnt 0, WB_o_halt 0, WBU_o_ready 1 after release; strobes drop immediately at assertion.
- Upstream must hold fields stable while MEM_o_valid & !WBU_o_ready.

## Structure
- Shared package: state enum (IDLE/WRITE/HALT), MCAUSE_ECALL_M = 11, load-size struct.
- Sub-module ysyx_23060136_WBU_LOAD_EXT: combinational load extension; FSM, entry register and counter in top.

## Test plan
- Single addi x5 result 0x1234, write_gpr=1 -> one cycle later RegWr=1, rd=5, busW=0x1234, commit=1, retire_cnt=1.
- Load byte, mem_rdata=0x80, mem_byte=1 -> busW=0xFFFF_FFFF_FFFF_FF80; same with byte_u -> 0x80.
- rd=0 with write_gpr=1 -> RegWr=0, commit still 1.
- ecall at pc=0x8000_0010 -> CSRWr_1=CSRWr_2=1, busW_1=0x8000_0010, busW_2=11.
- 8 back-to-back valid entries -> 8 consecutive commit pulses, ready never low, retire_cnt=8.
- system_halt entry followed by valid traffic -> halt entry commits, WB_o_halt=1 next cycle, ready=0, no further strobes; async reset mid-WRITE -> strobes 0 immediately, counter 0.
